// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   MEM stage of the 5-stage MIPS pipeline. It registers the execute-stage
//   results and runs loads/stores over a req/ack data-memory port. Load data
//   is lane-aligned and sign/zero-extended. Upstream is stalled while an access
//   is outstanding. A registered write-back bundle is presented to WB.
//
// Parameters
//   TIMEOUT       maximum cycles dmem_req is held without dmem_ack (>= 2)
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   ex_*          instruction fields from execute_stage, taken on ex_valid && !stall
//   stall         upstream must hold; high for every cycle an access is pending
//   dmem_req/we/addr/be/wdata   data-memory request, held stable until dmem_ack
//   dmem_ack/rdata              access completion and read data (same cycle)
//   wb_valid/en/dest/data       write-back bundle (wb_valid is a 1-cycle pulse)
//   exc_ovf, exc_misalign, bus_err   exception pulses qualified by wb_valid
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_shift_res,
  input  logic [31:0] ex_dm_in,
  input  logic [31:0] ex_ea,
  input  logic        ex_ovfalu,
  input  logic        ex_res_sel,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_dest,
  input  logic        ex_wb_en,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        exc_ovf,
  output logic        exc_misalign,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  // Size encoding: 00 byte, 01 half, 1x word.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    if (size == 2'b00)      be = 4'b0001 << lo;
    else if (size == 2'b01) be = lo[1] ? 4'b1100 : 4'b0011;
    else                    be = 4'b1111;
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    if (size == 2'b00)      w = {4{d[7:0]}};
    else if (size == 2'b01) w = {2{d[15:0]}};
    else                    w = d;
    return w;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        uns,
                                              input logic [31:0] rdata);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    shifted = rdata >> {lo, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    if (size == 2'b00) begin
      s = b;
      return uns ? {24'd0, shifted[7:0]} : s;
    end else if (size == 2'b01) begin
      s = h;
      return uns ? {16'd0, shifted[15:0]} : s;
    end
    return rdata;
  endfunction

  logic is_mem;
  logic ex_misalign;
  logic accept;

  assign is_mem      = ex_is_load | ex_is_store;
  assign ex_misalign = misaligned(ex_size, ex_ea[1:0]);
  assign accept      = ex_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !ex_misalign) state_d = ACCESS;
      ACCESS:  if (dmem_ack || (cnt_q == CNT_LAST))  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timeout counter: counts ACCESS cycles without ack, cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if ((state_q == ACCESS) && !dmem_ack && (cnt_q != CNT_LAST))
      cnt_q <= cnt_q + 1'b1;
    else
      cnt_q <= '0;
  end

  // ---- stage p1: memory-op fields captured at accept ----
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  logic [3:0]  be_p1;
  logic        we_p1;
  logic [1:0]  lo_p1;
  logic [1:0]  size_p1;
  logic        uns_p1;
  logic [4:0]  dest_p1;
  logic        wb_en_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= {ex_ea[31:2], 2'b00};
      wdata_p1 <= lane_wdata(ex_size, ex_dm_in);
      be_p1    <= lane_be(ex_size, ex_ea[1:0]);
      we_p1    <= ex_is_store;
      lo_p1    <= ex_ea[1:0];
      size_p1  <= ex_size;
      uns_p1   <= ex_unsigned;
      dest_p1  <= ex_dest;
      wb_en_p1 <= ex_wb_en;
    end
  end

  // The request is decoded from state so an async reset removes it at once;
  // the remaining bus fields are gated so they read 0 whenever idle.
  assign stall      = (state_q == ACCESS);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & we_p1;
  assign dmem_addr  = dmem_req ? addr_p1  : 32'd0;
  assign dmem_be    = dmem_req ? be_p1    : 4'd0;
  assign dmem_wdata = dmem_req ? wdata_p1 : 32'd0;

  // ---- stage p2: write-back bundle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      wb_dest      <= 5'd0;
      wb_data      <= 32'd0;
      exc_ovf      <= 1'b0;
      exc_misalign <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      exc_ovf      <= 1'b0;
      exc_misalign <= 1'b0;
      bus_err      <= 1'b0;
      if (state_q == IDLE) begin
        if (accept && !is_mem) begin
          wb_valid <= 1'b1;
          wb_en    <= ex_wb_en & ~ex_ovfalu;
          wb_dest  <= ex_dest;
          wb_data  <= ex_res_sel ? ex_shift_res : ex_alu_res;
          exc_ovf  <= ex_ovfalu;
        end else if (accept && ex_misalign) begin
          wb_valid     <= 1'b1;
          wb_dest      <= ex_dest;
          wb_data      <= 32'd0;
          exc_misalign <= 1'b1;
        end
      end else begin
        // An ack in the final timeout cycle still completes normally.
        if (dmem_ack) begin
          wb_valid <= 1'b1;
          wb_dest  <= dest_p1;
          if (we_p1) begin
            wb_data <= 32'd0;
          end else begin
            wb_en   <= wb_en_p1;
            wb_data <= load_extend(size_p1, lo_p1, uns_p1, dmem_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          wb_valid <= 1'b1;
          wb_dest  <= dest_p1;
          wb_data  <= 32'd0;
          bus_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_res, ex_shift_res, ex_dm_in, ex_ea;
  logic        ex_ovfalu, ex_res_sel, ex_is_load, ex_is_store;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_dest;
  logic        ex_wb_en;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        exc_ovf, exc_misalign, bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int reqs;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .ex_alu_res(ex_alu_res), .ex_shift_res(ex_shift_res), .ex_dm_in(ex_dm_in),
    .ex_ea(ex_ea), .ex_ovfalu(ex_ovfalu), .ex_res_sel(ex_res_sel),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .exc_ovf(exc_ovf), .exc_misalign(exc_misalign), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_alu_res = 0; ex_shift_res = 0; ex_dm_in = 0; ex_ea = 0;
    ex_ovfalu = 0; ex_res_sel = 0; ex_is_load = 0; ex_is_store = 0; ex_size = 0;
    ex_unsigned = 0; ex_dest = 0; ex_wb_en = 0;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [31:0] sh, input logic sel,
                        input logic ovf, input logic [4:0] dest);
    clr_ex();
    ex_valid = 1; ex_alu_res = alu; ex_shift_res = sh; ex_res_sel = sel;
    ex_ovfalu = ovf; ex_dest = dest; ex_wb_en = 1;
  endtask

  task automatic mem_op(input logic ld, input logic [1:0] size, input logic uns,
                        input logic [31:0] ea, input logic [31:0] dm, input logic [4:0] dest);
    clr_ex();
    ex_valid = 1; ex_is_load = ld; ex_is_store = ~ld; ex_size = size;
    ex_unsigned = uns; ex_ea = ea; ex_dm_in = dm; ex_dest = dest; ex_wb_en = ld;
  endtask

  // Serve the outstanding request, acking on req cycle ack_at (negative: never).
  // Returns with the bench one cycle past the last request cycle.
  task automatic serve(input int ack_at, input logic [31:0] rdata, output int req_cycles);
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!dmem_req) break;
      req_cycles++;
      dmem_rdata = rdata;
      dmem_ack   = (k == ack_at);
      step();
      dmem_ack = 0;
    end
  endtask

  initial begin
    clr_ex();
    dmem_ack = 0; dmem_rdata = 0;
    rst_n = 0;
    step(); step();
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);
    rst_n = 1;
    step();

    // ADDU -> latency 1
    alu_op(32'h0000_1234, 32'hDEAD_0000, 0, 0, 5'd5);
    chk("addu_stall_pre", {31'd0, stall}, 0);
    step();
    clr_ex();
    chk("addu_valid", {31'd0, wb_valid}, 1);
    chk("addu_data", wb_data, 32'h0000_1234);
    chk("addu_dest", {27'd0, wb_dest}, 5);
    chk("addu_en", {31'd0, wb_en}, 1);
    chk("addu_stall", {31'd0, stall}, 0);
    step();
    chk("addu_pulse", {31'd0, wb_valid}, 0);
    chk("addu_hold", wb_data, 32'h0000_1234);

    // Shift-select with overflow, then back-to-back ALU op
    alu_op(32'h0000_0001, 32'h0000_00F0, 1, 1, 5'd9);
    step();
    chk("ovf_valid", {31'd0, wb_valid}, 1);
    chk("ovf_data", wb_data, 32'h0000_00F0);
    chk("ovf_exc", {31'd0, exc_ovf}, 1);
    chk("ovf_en", {31'd0, wb_en}, 0);
    alu_op(32'h0000_0077, 32'h0, 0, 0, 5'd10);
    step();
    clr_ex();
    chk("b2b_valid", {31'd0, wb_valid}, 1);
    chk("b2b_data", wb_data, 32'h0000_0077);
    chk("b2b_exc", {31'd0, exc_ovf}, 0);
    chk("b2b_en", {31'd0, wb_en}, 1);

    // LB ea=0x103, ack on third request cycle
    mem_op(1, 2'b00, 0, 32'h0000_0103, 32'h0, 5'd7);
    step();
    clr_ex();
    chk("lb_req", {31'd0, dmem_req}, 1);
    chk("lb_stall", {31'd0, stall}, 1);
    chk("lb_we", {31'd0, dmem_we}, 0);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_be", {28'd0, dmem_be}, 4'b1000);
    serve(2, 32'h80AA_BBCC, reqs);
    chk("lb_req_cycles", reqs, 3);
    chk("lb_valid", {31'd0, wb_valid}, 1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_stall_drop", {31'd0, stall}, 0);
    chk("lb_en", {31'd0, wb_en}, 1);

    // LBU same address
    mem_op(1, 2'b00, 1, 32'h0000_0103, 32'h0, 5'd8);
    step();
    clr_ex();
    serve(2, 32'h80AA_BBCC, reqs);
    chk("lbu_data", wb_data, 32'h0000_0080);
    chk("lbu_dest", {27'd0, wb_dest}, 8);

    // LH upper half, signed
    mem_op(1, 2'b01, 0, 32'h0000_0102, 32'h0, 5'd3);
    step();
    clr_ex();
    chk("lh_be", {28'd0, dmem_be}, 4'b1100);
    serve(0, 32'h8001_7FFF, reqs);
    chk("lh_data", wb_data, 32'hFFFF_8001);

    // SH ea=0x202, ack on first request cycle
    mem_op(0, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 5'd4);
    step();
    clr_ex();
    chk("sh_we", {31'd0, dmem_we}, 1);
    chk("sh_be", {28'd0, dmem_be}, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    serve(0, 32'h0, reqs);
    chk("sh_req_cycles", reqs, 1);
    chk("sh_valid", {31'd0, wb_valid}, 1);
    chk("sh_en", {31'd0, wb_en}, 0);

    // SB ea=0x101
    mem_op(0, 2'b00, 0, 32'h0000_0101, 32'h0000_0055, 5'd0);
    step();
    clr_ex();
    chk("sb_be", {28'd0, dmem_be}, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'h5555_5555);
    serve(0, 32'h0, reqs);

    // LW ea=0x301 misaligned, then ADD back-to-back
    mem_op(1, 2'b10, 0, 32'h0000_0301, 32'h0, 5'd6);
    chk("mis_req_pre", {31'd0, dmem_req}, 0);
    step();
    chk("mis_req", {31'd0, dmem_req}, 0);
    chk("mis_valid", {31'd0, wb_valid}, 1);
    chk("mis_exc", {31'd0, exc_misalign}, 1);
    chk("mis_en", {31'd0, wb_en}, 0);
    chk("mis_stall", {31'd0, stall}, 0);
    alu_op(32'h0000_0042, 32'h0, 0, 0, 5'd11);
    step();
    clr_ex();
    chk("mis_add_valid", {31'd0, wb_valid}, 1);
    chk("mis_add_data", wb_data, 32'h0000_0042);
    chk("mis_add_exc", {31'd0, exc_misalign}, 0);
    chk("mis_add_req", {31'd0, dmem_req}, 0);

    // LW aligned, word read
    mem_op(1, 2'b10, 0, 32'h0000_0104, 32'h0, 5'd12);
    step();
    clr_ex();
    chk("lw_be", {28'd0, dmem_be}, 4'b1111);
    serve(1, 32'hCAFE_BABE, reqs);
    chk("lw_data", wb_data, 32'hCAFE_BABE);

    // LW with no ack: timeout
    mem_op(1, 2'b10, 0, 32'h0000_0400, 32'h0, 5'd13);
    step();
    clr_ex();
    serve(-1, 32'h0, reqs);
    chk("to_req_cycles", reqs, 16);
    chk("to_valid", {31'd0, wb_valid}, 1);
    chk("to_bus_err", {31'd0, bus_err}, 1);
    chk("to_en", {31'd0, wb_en}, 0);
    chk("to_stall", {31'd0, stall}, 0);
    step();
    chk("to_pulse", {31'd0, bus_err}, 0);

    // Ack in the final timeout cycle wins
    mem_op(1, 2'b10, 0, 32'h0000_0408, 32'h0, 5'd14);
    step();
    clr_ex();
    serve(15, 32'h1357_9BDF, reqs);
    chk("tolast_req_cycles", reqs, 16);
    chk("tolast_bus_err", {31'd0, bus_err}, 0);
    chk("tolast_valid", {31'd0, wb_valid}, 1);
    chk("tolast_data", wb_data, 32'h1357_9BDF);

    // Async reset in the middle of an access
    mem_op(1, 2'b10, 0, 32'h0000_0500, 32'h0, 5'd15);
    step();
    clr_ex();
    chk("ar_req_before", {31'd0, dmem_req}, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_req", {31'd0, dmem_req}, 0);
    chk("ar_stall", {31'd0, stall}, 0);
    chk("ar_valid", {31'd0, wb_valid}, 0);
    step();
    #3 rst_n = 1;
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 0;
    chk("late_ack_valid", {31'd0, wb_valid}, 0);
    chk("late_ack_req", {31'd0, dmem_req}, 0);
    chk("late_ack_stall", {31'd0, stall}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
